// File: rtl/gate_truth_checker.sv
// Truth-table sequencer: steps a gate under test through every input vector,
// samples its response after a settle time and accumulates mismatches.
module gate_truth_checker #(
   parameter int                   N_IN     = 2,
   parameter int                   SETTLE   = 1,
   parameter logic [(2**N_IN)-1:0] EXPECTED = 4'b0111
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        stim,
   input  logic                   resp,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [(2**N_IN)-1:0]   fail_mask,
   output logic [N_IN:0]          err_count
);

   localparam int              NV         = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(NV - 1);
   localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [N_IN-1:0]   r_idx;
   logic [3:0]        r_cnt;
   logic [NV-1:0]     r_fail_mask;
   logic [N_IN:0]     r_err_count;
   logic              r_pass;

   logic              w_sample;
   logic              w_last;
   logic              w_mismatch;

   assign w_sample   = (r_state == S_APPLY) && (r_cnt == SETTLE_CNT);
   assign w_last     = (r_idx == LAST_IDX);
   // Case inequality so an undriven or X response is treated as a failure.
   assign w_mismatch = (resp !== EXPECTED[r_idx]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      stim         = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_APPLY;
            end
         end
         S_APPLY: begin
            stim = r_idx;
            busy = 1'b1;
            if (w_sample && w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= '0;
         r_cnt       <= '0;
         r_fail_mask <= '0;
         r_err_count <= '0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_fail_mask <= '0;
                  r_err_count <= '0;
                  r_pass      <= 1'b0;
               end
            end
            S_APPLY: begin
               if (w_sample) begin
                  if (w_mismatch) begin
                     r_fail_mask[r_idx] <= 1'b1;
                     r_err_count        <= r_err_count + (N_IN+1)'(1);
                  end
                  if (!w_last) begin
                     r_idx <= r_idx + N_IN'(1);
                     r_cnt <= '0;
                  end else begin
                     // Final verdict must include the mismatch of this last sample.
                     r_pass <= !w_mismatch && (r_err_count == '0);
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fail_mask = r_fail_mask;
   assign err_count = r_err_count;
   assign pass      = r_pass;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three instances (SETTLE 1/3/0) driven from a
// result table, plus reset-mid-run and held-start sequences.
module tb_gate_truth_checker;

   typedef struct {
      logic       pass;
      logic [3:0] mask;
      logic [2:0] err;
      int         lat;
   } res_t;

   typedef struct {
      int   sel;
      int   mode;
      res_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b, start_c;
   int         mode;
   logic [1:0] stim_a, stim_b, stim_c;
   logic       resp_a, resp_b, resp_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;
   logic       pass_a, pass_b, pass_c;
   logic [3:0] mask_a, mask_b, mask_c;
   logic [2:0] err_a, err_b, err_c;
   logic [2:0] pipe_b, pipe_c;

   int checks   = 0;
   int failures = 0;
   res_t sb_q[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   // Gate models: instance a is combinational (NAND/AND/stuck-1/stuck-0),
   // instances b and c see a NAND behind three register stages.
   always_comb begin
      case (mode)
         0:       resp_a = ~&stim_a;
         1:       resp_a = &stim_a;
         2:       resp_a = 1'b1;
         default: resp_a = 1'b0;
      endcase
   end
   always @(posedge clk) begin
      pipe_b <= {pipe_b[1:0], ~&stim_b};
      pipe_c <= {pipe_c[1:0], ~&stim_c};
   end
   assign resp_b = pipe_b[2];
   assign resp_c = pipe_c[2];

   gate_truth_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b0111)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .resp(resp_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(mask_a), .err_count(err_a));
   gate_truth_checker #(.N_IN(2), .SETTLE(3), .EXPECTED(4'b0111)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .resp(resp_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .fail_mask(mask_b), .err_count(err_b));
   gate_truth_checker #(.N_IN(2), .SETTLE(0), .EXPECTED(4'b0111)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .resp(resp_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .fail_mask(mask_c), .err_count(err_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int sel, input int md, input logic p,
                               input logic [3:0] m, input logic [2:0] e, input int lat);
      vec_t v;
      v.sel      = sel;
      v.mode     = md;
      v.exp.pass = p;
      v.exp.mask = m;
      v.exp.err  = e;
      v.exp.lat  = lat;
      return v;
   endfunction

   function automatic int settle_of(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 3 : 0;
   endfunction

   task automatic snap(input int sel, output logic [1:0] st, output logic bz, output logic dn,
                       output logic ps, output logic [3:0] fm, output logic [2:0] ec);
      case (sel)
         0:       begin st = stim_a; bz = busy_a; dn = done_a; ps = pass_a; fm = mask_a; ec = err_a; end
         1:       begin st = stim_b; bz = busy_b; dn = done_b; ps = pass_b; fm = mask_b; ec = err_b; end
         default: begin st = stim_c; bz = busy_c; dn = done_c; ps = pass_c; fm = mask_c; ec = err_c; end
      endcase
   endtask

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   // One complete run: pushes the expected result, pulses start, follows the
   // stimulus trace, and pops/compares when done appears.
   task automatic run_one(input int row, input int sel, input res_t exp);
      logic [1:0] st, trace[$];
      logic       bz, dn, ps;
      logic [3:0] fm;
      logic [2:0] ec;
      res_t       want;
      int         lat = -1;
      int         s   = settle_of(sel);
      repeat (2) @(negedge clk);
      sb_q.push_back(exp);
      set_start(sel, 1'b1);
      for (int e = 0; e < 4 * (s + 1) + 12; e++) begin
         @(posedge clk);
         #1;
         if (e == 0) set_start(sel, 1'b0);
         snap(sel, st, bz, dn, ps, fm, ec);
         if (bz) trace.push_back(st);
         if (dn) begin
            lat = e;
            break;
         end
      end
      want = sb_q.pop_front();
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL row%0d_done_timeout actual=none required=%0d", row, want.lat);
      end else begin
         check($sformatf("row%0d_latency", row), lat, want.lat);
         check($sformatf("row%0d_pass", row), ps, want.pass);
         check($sformatf("row%0d_fail_mask", row), fm, want.mask);
         check($sformatf("row%0d_err_count", row), ec, want.err);
         check($sformatf("row%0d_busy_in_done", row), bz, 0);
         check($sformatf("row%0d_stim_in_done", row), st, 0);
      end
      check($sformatf("row%0d_trace_len", row), trace.size(), 4 * (s + 1));
      for (int k = 0; k < trace.size() && k < 4 * (s + 1); k++) begin
         logic [1:0] ev = 2'(k / (s + 1));
         check($sformatf("row%0d_stim[%0d]", row, k), trace[k], ev);
      end
      $display("run row=%0d sel=%0d mode=%0d lat=%0d pass=%0b mask=%b err=%0d",
               row, sel, mode, lat, ps, fm, ec);
   endtask

   task automatic wait_done_a(input int first, input int budget, output int lat);
      lat = -1;
      for (int e = first; e < first + budget; e++) begin
         @(posedge clk);
         #1;
         if (done_a) begin
            lat = e;
            break;
         end
      end
   endtask

   initial begin
      int   lat;
      int   dcount;
      logic found;
      res_t r;

      vecs[0] = mk(0, 0, 1'b1, 4'b0000, 3'd0, 8);   // NAND
      vecs[1] = mk(0, 1, 1'b0, 4'b1111, 3'd4, 8);   // AND
      vecs[2] = mk(0, 2, 1'b0, 4'b1000, 3'd1, 8);   // stuck-at-1
      vecs[3] = mk(0, 3, 1'b0, 4'b0111, 3'd3, 8);   // stuck-at-0
      vecs[4] = mk(1, 0, 1'b1, 4'b0000, 3'd0, 16);  // delayed NAND, SETTLE=3
      vecs[5] = mk(2, 0, 1'b0, 4'b1000, 3'd1, 4);   // delayed NAND, SETTLE=0

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; mode = 0;
      repeat (5) @(posedge clk);
      #1;
      check("reset_stim", stim_a, 0);
      check("reset_busy", busy_a, 0);
      check("reset_done", done_a, 0);
      check("reset_pass", pass_a, 0);
      check("reset_mask", mask_a, 0);
      check("reset_err", err_a, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         mode = vecs[i].mode;
         run_one(i, vecs[i].sel, vecs[i].exp);
      end

      // Reset in the middle of a failing run.
      mode = 1;
      repeat (2) @(negedge clk);
      start_a = 1'b1;
      found = 1'b0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk);
         #1;
         start_a = 1'b0;
         if (stim_a == 2'd2) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_reached_stim2", found, 1);
      check("rst_mask_before", mask_a, 4'b0011);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_stim", stim_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_pass", pass_a, 0);
      check("rst_mask", mask_a, 0);
      check("rst_err", err_a, 0);
      dcount = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk);
         #1;
         if (done_a) dcount++;
      end
      check("rst_no_done_pulses", dcount, 0);
      $display("reset_mid_run done_pulses=%0d", dcount);
      mode = 0;
      r.pass = 1'b1; r.mask = 4'b0000; r.err = 3'd0; r.lat = 8;
      run_one(6, 0, r);

      // start held high across back-to-back runs.
      repeat (2) @(negedge clk);
      start_a = 1'b1;
      wait_done_a(0, 20, lat);
      check("hold_run1_latency", lat, 8);
      check("hold_run1_pass", pass_a, 1);
      @(posedge clk);
      #1;
      check("hold_idle_busy", busy_a, 0);
      check("hold_idle_stim", stim_a, 0);
      check("hold_idle_pass_held", pass_a, 1);
      @(posedge clk);
      #1;
      check("hold_restart_busy", busy_a, 1);
      check("hold_restart_pass", pass_a, 0);
      check("hold_restart_err", err_a, 0);
      mode = 1;
      wait_done_a(1, 20, lat);
      check("hold_run2_latency", lat, 8);
      check("hold_run2_mask", mask_a, 4'b1111);
      check("hold_run2_err", err_a, 4);
      @(posedge clk);
      #1;
      check("hold_idle2_mask_held", mask_a, 4'b1111);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      check("hold_restart2_busy", busy_a, 1);
      check("hold_restart2_mask", mask_a, 0);
      check("hold_restart2_err", err_a, 0);
      wait_done_a(1, 20, lat);
      check("hold_run3_latency", lat, 8);
      $display("held_start run3 lat=%0d mask=%b", lat, mask_a);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
